sram_arbiter: RTL and testbench

Multi-port controller that shares the single external 16-bit asynchronous SRAM between several 32-bit word read requesters and write requesters (CPU instruction/data ports, SD boot loader, future DMA). It replaces direct SRAM wiring in the top level. Each granted request becomes two sequenced 16-bit SRAM accesses. Grants are round-robin across all requesters. The data-bus tristate buffer and chip-enable tie-off stay in the top level.

---
 rtl/sram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that shares one 16-bit asynchronous SRAM
// among several 32-bit word read and write requesters. Each grant becomes a
// low-halfword access followed by a high-halfword access, then a one-cycle
// ready pulse to the granted requester. All outputs are registered.
module sram_arbiter #(
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    parameter int ADDR_WIDTH    = 19,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_READ-1:0]              rd_req,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
    output logic [31:0]                      rd_data,
    output logic [NUM_READ-1:0]              rd_ready,
    input  logic [NUM_WRITE-1:0]             wr_req,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_WRITE*32-1:0]          wr_data,
    output logic [NUM_WRITE-1:0]             wr_ready,
    output logic [ADDR_WIDTH:0]              sram_addr,
    output logic [15:0]                      sram_dq_out,
    output logic                             sram_dq_oe,
    input  logic [15:0]                      sram_dq_in,
    output logic                             sram_oe_n,
    output logic                             sram_we_n,
    output logic                             sram_ub_n,
    output logic                             sram_lb_n
);

    localparam int N     = NUM_READ + NUM_WRITE;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1) + 1;

    // A read half is ACCESS_CYCLES long; a write half adds one setup cycle.
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(ACCESS_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_wr;
    logic [ADDR_WIDTH-1:0]  gnt_addr;
    logic [15:0]            gnt_hi;
    logic [15:0]            lo_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       last;

    logic [N-1:0]           req_all;
    logic                   found;
    logic [IDX_W-1:0]       win;
    logic                   win_wr;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [31:0]            win_data;

    // Reads occupy indices 0..NUM_READ-1, writes follow.
    assign req_all = {wr_req, rd_req};
    assign last    = gnt_wr ? LAST_WR : LAST_RD;

    // Round-robin pick: the asserted requester at the smallest circular distance from ptr.
    always_comb begin
        int best;
        best  = N;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = i - int'(ptr);
            if (d < 0) d = d + N;
            if (req_all[i] && d < best) begin
                best = d;
                win  = IDX_W'(i);
            end
        end
        found = (best < N);
    end

    // Route the winner's address, direction and write data.
    always_comb begin
        win_wr   = (int'(win) >= NUM_READ);
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (int'(win) == i) win_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (int'(win) == NUM_READ + j) begin
                win_addr = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = wr_data[j*32 +: 32];
            end
        end
    end

    // Access sequencer: grant in IDLE, low half, high half, ready pulse in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_idx     <= '0;
            gnt_wr      <= 1'b0;
            gnt_addr    <= '0;
            gnt_hi      <= '0;
            lo_q        <= '0;
            cnt         <= '0;
            rd_data     <= '0;
            rd_ready    <= '0;
            wr_ready    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    rd_ready <= '0;
                    wr_ready <= '0;
                    if (found) begin
                        gnt_idx     <= win;
                        gnt_wr      <= win_wr;
                        gnt_addr    <= win_addr;
                        gnt_hi      <= win_data[31:16];
                        ptr         <= (int'(win) == N - 1) ? '0 : win + IDX_W'(1);
                        cnt         <= '0;
                        sram_addr   <= {win_addr, 1'b0};
                        sram_dq_out <= win_data[15:0];
                        sram_dq_oe  <= win_wr;
                        sram_oe_n   <= win_wr;
                        // Writes open with a setup cycle, so WE stays high here.
                        sram_we_n   <= 1'b1;
                        sram_ub_n   <= 1'b0;
                        sram_lb_n   <= 1'b0;
                        state       <= LO;
                    end
                end
                LO, HI: begin
                    if (cnt == last) begin
                        cnt <= '0;
                        if (state == LO) begin
                            lo_q        <= sram_dq_in;
                            sram_addr   <= {gnt_addr, 1'b1};
                            sram_dq_out <= gnt_hi;
                            sram_we_n   <= 1'b1;
                            state       <= HI;
                        end else begin
                            sram_dq_oe <= 1'b0;
                            sram_oe_n  <= 1'b1;
                            sram_we_n  <= 1'b1;
                            sram_ub_n  <= 1'b1;
                            sram_lb_n  <= 1'b1;
                            if (!gnt_wr) rd_data <= {sram_dq_in, lo_q};
                            for (int i = 0; i < NUM_READ; i++)
                                rd_ready[i] <= !gnt_wr && (int'(gnt_idx) == i);
                            for (int j = 0; j < NUM_WRITE; j++)
                                wr_ready[j] <= gnt_wr && (int'(gnt_idx) == NUM_READ + j);
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (gnt_wr) sram_we_n <= 1'b0;
                    end
                end
                DONE: begin
                    rd_ready <= '0;
                    wr_ready <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural asynchronous SRAM.
module tb_sram_arbiter;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 19;
    localparam int AC = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [31:0]     rd_data;
    logic [NR-1:0]   rd_ready;
    logic [NW-1:0]   wr_req;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*32-1:0] wr_data;
    logic [NW-1:0]   wr_ready;
    logic [AW:0]     sram_addr;
    logic [15:0]     sram_dq_out;
    logic            sram_dq_oe;
    logic [15:0]     sram_dq_in;
    logic            sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int vectors = 0;
    int miscompares = 0;

    sram_arbiter #(
        .NUM_READ(NR), .NUM_WRITE(NW), .ADDR_WIDTH(AW), .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // SRAM model: preload port, write on a clock edge while WE is low, combinational read.
    logic [15:0] mem [0:(1<<20)-1];
    logic        pre_en = 1'b0;
    logic [19:0] pre_addr = '0;
    logic [15:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (!sram_we_n && sram_dq_oe && !sram_ub_n && !sram_lb_n)
            mem[sram_addr] <= sram_dq_out;
    end

    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [19:0] a, input logic [15:0] v);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        step();
        pre_en   = 1'b0;
    endtask

    initial begin
        int         oe_low;
        int         npulse;
        logic [15:0] order;
        logic [5:0] we_seq;
        logic [5:0] dqoe_seq;
        logic       got;

        reset   = 1'b0;
        rd_req  = '0;
        wr_req  = '0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        #2 reset = 1'b1;
        preload(20'h00020, 16'hBEEF);
        preload(20'h00021, 16'hDEAD);

        // Reset state
        chk("rst_rd_ready", 32'(rd_ready), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        chk("rst_strobes", 32'({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'hF);
        reset = 1'b0;
        step();

        // Single read of word 0x10
        rd_addr = {19'h0, 19'h10};
        rd_req  = 2'b01;
        oe_low  = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (!sram_oe_n) oe_low++;
            if (k == 1) chk("t1_lo_addr", 32'(sram_addr), 32'h20);
            if (k == 3) chk("t1_hi_addr", 32'(sram_addr), 32'h21);
            if (k == 4) chk("t1_not_yet_ready", 32'(rd_ready), 32'h0);
            if (k == 5) begin
                chk("t1_rd_ready", 32'(rd_ready), 32'h1);
                chk("t1_rd_data", rd_data, 32'hDEADBEEF);
                rd_req = 2'b00;
            end
        end
        chk("t1_oe_low_cycles", 32'(oe_low), 32'd4);
        step();
        chk("t1_ready_one_cycle", 32'(rd_ready), 32'h0);

        // Write 0x12345678 to the top word, checking strobe shape
        wr_addr = {19'h0, 19'h7FFFF};
        wr_data = {32'h0, 32'h12345678};
        wr_req  = 2'b01;
        oe_low  = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k <= 6) begin
                we_seq[6-k]   = sram_we_n;
                dqoe_seq[6-k] = sram_dq_oe;
                if (!sram_oe_n) oe_low++;
            end
            if (k == 1) begin
                chk("t2_lo_addr", 32'(sram_addr), 32'hFFFFE);
                chk("t2_lo_dq", 32'(sram_dq_out), 32'h5678);
            end
            if (k == 4) begin
                chk("t2_hi_addr", 32'(sram_addr), 32'hFFFFF);
                chk("t2_hi_dq", 32'(sram_dq_out), 32'h1234);
            end
            if (k == 6) chk("t2_not_yet_ready", 32'(wr_ready), 32'h0);
            if (k == 7) begin
                chk("t2_wr_ready", 32'(wr_ready), 32'h1);
                wr_req = 2'b00;
            end
        end
        chk("t2_we_shape", 32'(we_seq), 32'h24);
        chk("t2_dq_oe_shape", 32'(dqoe_seq), 32'h3F);
        chk("t2_oe_never_low", 32'(oe_low), 32'd0);
        step();
        chk("t2_mem_lo", 32'(mem[20'hFFFFE]), 32'h5678);
        chk("t2_mem_hi", 32'(mem[20'hFFFFF]), 32'h1234);

        // Read the word back through rd1
        rd_addr = {19'h7FFFF, 19'h10};
        rd_req  = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) begin
                chk("t2_rb_ready", 32'(rd_ready), 32'h2);
                chk("t2_rb_data", rd_data, 32'h12345678);
                rd_req = 2'b00;
            end
        end
        step();

        // All four requesters at once straight out of reset
        reset = 1'b1;
        step();
        wr_addr = {19'h101, 19'h100};
        wr_data = {32'h0F0FF0F0, 32'hAAAA5555};
        rd_req  = 2'b11;
        wr_req  = 2'b11;
        step();
        reset  = 1'b0;
        npulse = 0;
        order  = '0;
        for (int c = 0; c < 40 && npulse < 4; c++) begin
            step();
            if (rd_ready[0]) begin
                order = (order << 4) | 16'h0; npulse++; rd_req[0] = 1'b0;
                chk("t3_rd0_data", rd_data, 32'hDEADBEEF);
            end
            if (rd_ready[1]) begin
                order = (order << 4) | 16'h1; npulse++; rd_req[1] = 1'b0;
                chk("t3_rd1_data", rd_data, 32'h12345678);
            end
            if (wr_ready[0]) begin order = (order << 4) | 16'h2; npulse++; wr_req[0] = 1'b0; end
            if (wr_ready[1]) begin order = (order << 4) | 16'h3; npulse++; wr_req[1] = 1'b0; end
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (rd_ready != 2'b00 || wr_ready != 2'b00) npulse++;
        end
        chk("t3_pulse_count", 32'(npulse), 32'd4);
        chk("t3_grant_order", 32'(order), 32'h0123);
        chk("t3_mem_wr0_lo", 32'(mem[20'h00200]), 32'h5555);
        chk("t3_mem_wr0_hi", 32'(mem[20'h00201]), 32'hAAAA);
        chk("t3_mem_wr1_lo", 32'(mem[20'h00202]), 32'hF0F0);
        chk("t3_mem_wr1_hi", 32'(mem[20'h00203]), 32'h0F0F);

        // Fairness: rd0 and wr1 both held high
        wr_addr = {19'h180, 19'h100};
        wr_data = {32'hCAFEF00D, 32'hAAAA5555};
        rd_req  = 2'b01;
        wr_req  = 2'b10;
        npulse  = 0;
        order   = '0;
        for (int c = 0; c < 60 && npulse < 4; c++) begin
            step();
            if (rd_ready[0]) begin order = (order << 4) | 16'h0; npulse++; end
            if (wr_ready[1]) begin order = (order << 4) | 16'h3; npulse++; end
        end
        rd_req = 2'b00;
        wr_req = 2'b00;
        chk("t4_pulse_count", 32'(npulse), 32'd4);
        chk("t4_alternation", 32'(order), 32'h0303);
        step();
        step();
        chk("t4_idle_strobes", 32'({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'hF);
        chk("t4_mem_wr1_hi", 32'(mem[20'h00301]), 32'hCAFE);

        // Reset in the second cycle of a write high half
        wr_addr = {19'h180, 19'h300};
        wr_data = {32'hCAFEF00D, 32'h55AA33CC};
        wr_req  = 2'b01;
        for (int k = 1; k <= 5; k++) step();
        chk("t5_mid_hi_we", 32'(sram_we_n), 32'h0);
        reset = 1'b1;
        #1;
        chk("t5_rst_strobes", 32'({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'hF);
        chk("t5_rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        step();
        chk("t5_no_wr_ready_a", 32'(wr_ready), 32'h0);
        step();
        chk("t5_no_wr_ready_b", 32'(wr_ready), 32'h0);
        reset  = 1'b0;
        wr_req = 2'b10;
        rd_addr = {19'h7FFFF, 19'h10};
        rd_req  = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) begin
                chk("t5_rd0_first", 32'(rd_ready), 32'h1);
                chk("t5_wr_quiet", 32'(wr_ready), 32'h0);
                chk("t5_rd0_data", rd_data, 32'hDEADBEEF);
                rd_req = 2'b00;
            end
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (wr_ready[1]) got = 1'b1;
        end
        wr_req = 2'b00;
        chk("t5_wr1_completes", 32'(got), 32'h1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
